// File: rtl/float_mult_pipe.sv
// Pipelined floating-point multiplier {sign, exp, frac} with a pass-through tag.
// Latency 4: operands sampled at edge k give rdy in the cycle after edge k+4.
// No backpressure: one operation per cycle, and rdy is a one-cycle pulse per result.
// Optional feature macro FLOAT_MULT_RNE_EN: round-to-nearest-even (default is truncation).
module float_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic                 operation_nd,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 rdy,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     tag_out,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;           // significand width including hidden bit
  localparam int PW = 2 * SW;              // full product width
  localparam int EW = EXP_W + 2;           // signed exponent width with headroom
`ifdef FLOAT_MULT_RNE_EN
  localparam int KW = PW;                  // rounding needs every product bit for sticky
`else
  localparam int KW = MAN_W + 2;           // truncation only needs the top bits
`endif
  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

  // Operand classification carried down the pipe; nan covers 0 x inf as well.
  typedef struct packed {
    logic nan;
    logic inv;
    logic inf;
    logic zero;
  } cls_t;

  // ---------------- S1: unpack and classify ----------------
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  cls_t                   cls_d;
  logic signed [EW-1:0]   exp_d;

  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  // Classify operands; subnormals (exp = 0) are flushed to zero.
  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) & (fa == '0);
    b_inf  = (&eb) & (fb == '0);
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    cls_d      = '0;
    cls_d.inv  = (a_zero & b_inf) | (b_zero & a_inf);
    cls_d.nan  = a_nan | b_nan | cls_d.inv;
    cls_d.inf  = a_inf | b_inf;
    cls_d.zero = a_zero | b_zero;
    exp_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  end

  logic                 s1_vld, s1_sign;
  logic signed [EW-1:0] s1_exp;
  logic [MAN_W-1:0]     s1_fa, s1_fb;
  cls_t                 s1_cls;
  logic [TAG_W-1:0]     s1_tag;

  // Register the sampled operation in unpacked form.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      s1_vld <= 1'b0; s1_sign <= 1'b0; s1_exp <= '0;
      s1_fa  <= '0;   s1_fb   <= '0;   s1_cls <= '0; s1_tag <= '0;
    end else begin
      s1_vld <= operation_nd;
      if (operation_nd) begin
        s1_sign <= a[W-1] ^ b[W-1];
        s1_exp  <= exp_d;
        s1_fa   <= fa;
        s1_fb   <= fb;
        s1_cls  <= cls_d;
        s1_tag  <= tag_in;
      end
    end
  end

  // ---------------- S2: significand product ----------------
  logic                 s2_vld, s2_sign;
  logic signed [EW-1:0] s2_exp;
  logic [KW-1:0]        s2_prod;
  cls_t                 s2_cls;
  logic [TAG_W-1:0]     s2_tag;

  // Multiply the significands with hidden bits restored, keeping only the bits rounding needs.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      s2_vld <= 1'b0; s2_sign <= 1'b0; s2_exp <= '0;
      s2_prod <= '0;  s2_cls  <= '0;   s2_tag <= '0;
    end else begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_exp  <= s1_exp;
      s2_prod <= KW'(({{SW{1'b0}}, 1'b1, s1_fa} * {{SW{1'b0}}, 1'b1, s1_fb}) >> (PW - KW));
      s2_cls  <= s1_cls;
      s2_tag  <= s1_tag;
    end
  end

  // ---------------- S3: normalise and round ----------------
  logic                 top;
  logic [MAN_W-1:0]     man_n, man_r;
  logic signed [EW-1:0] exp_n, exp_r;
`ifdef FLOAT_MULT_RNE_EN
  logic                 guard, sticky, inc, carry;
`endif

  // Product is in [1,4): shift right one place when the MSB is set, then round.
  always_comb begin
    top   = s2_prod[KW-1];
    man_n = top ? s2_prod[KW-2 -: MAN_W] : s2_prod[KW-3 -: MAN_W];
    exp_n = s2_exp + (top ? EXP_ONE : EXP_ZERO);
`ifdef FLOAT_MULT_RNE_EN
    guard  = top ? s2_prod[KW-2-MAN_W] : s2_prod[KW-3-MAN_W];
    sticky = top ? (|s2_prod[KW-3-MAN_W:0]) : (|s2_prod[KW-4-MAN_W:0]);
    inc    = guard & (sticky | man_n[0]);
    {carry, man_r} = {1'b0, man_n} + {{MAN_W{1'b0}}, inc};
    // A carry out means the significand became 10.0...0; the fraction is already zero.
    exp_r  = carry ? exp_n + EXP_ONE : exp_n;
`else
    man_r = man_n;
    exp_r = exp_n;
`endif
  end

  logic                 s3_vld, s3_sign;
  logic signed [EW-1:0] s3_exp;
  logic [MAN_W-1:0]     s3_man;
  cls_t                 s3_cls;
  logic [TAG_W-1:0]     s3_tag;

  // Register the normalised, rounded significand and final exponent.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      s3_vld <= 1'b0; s3_sign <= 1'b0; s3_exp <= '0;
      s3_man <= '0;   s3_cls  <= '0;   s3_tag <= '0;
    end else begin
      s3_vld  <= s2_vld;
      s3_sign <= s2_sign;
      s3_exp  <= exp_r;
      s3_man  <= man_r;
      s3_cls  <= s2_cls;
      s3_tag  <= s2_tag;
    end
  end

  // ---------------- S4: exceptions and pack ----------------
  logic [W-1:0] res_d;
  logic         ovf_d, unf_d, inv_d;

  // Special operands first, then range checks on the rounded exponent.
  always_comb begin
    res_d = {s3_sign, s3_exp[EXP_W-1:0], s3_man};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (s3_cls.nan) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      inv_d = s3_cls.inv;
    end else if (s3_cls.inf) begin
      res_d = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s3_cls.zero) begin
      res_d = {s3_sign, {(W-1){1'b0}}};
    end else if (s3_exp >= EMAX) begin
      res_d = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else if (s3_exp[EW-1] || (s3_exp == EXP_ZERO)) begin
      res_d = {s3_sign, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  logic             s4_vld, s4_ovf, s4_unf, s4_inv;
  logic [W-1:0]     s4_res;
  logic [TAG_W-1:0] s4_tag;

  // Register the packed result and flags.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      s4_vld <= 1'b0; s4_ovf <= 1'b0; s4_unf <= 1'b0; s4_inv <= 1'b0;
      s4_res <= '0;   s4_tag <= '0;
    end else begin
      s4_vld <= s3_vld;
      s4_res <= res_d;
      s4_ovf <= s3_vld & ovf_d;
      s4_unf <= s3_vld & unf_d;
      s4_inv <= s3_vld & inv_d;
      s4_tag <= s3_tag;
    end
  end

  // Output register: result and tag hold through bubbles, flags only alongside rdy.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      rdy <= 1'b0; result <= '0; tag_out <= '0;
      overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0;
    end else begin
      rdy       <= s4_vld;
      overflow  <= s4_vld & s4_ovf;
      underflow <= s4_vld & s4_unf;
      invalid   <= s4_vld & s4_inv;
      if (s4_vld) begin
        result  <= s4_res;
        tag_out <= s4_tag;
      end
    end
  end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Directed bench for float_mult_pipe with single-precision parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_float_mult_pipe;

  logic        clk = 1'b0;
  logic        sclr = 1'b1;
  logic        operation_nd = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  tag_in = '0;
  logic        rdy;
  logic [31:0] result;
  logic [3:0]  tag_out;
  logic        overflow, underflow, invalid;

  int checks = 0;
  int errors = 0;

`ifdef FLOAT_MULT_RNE_EN
  localparam logic [31:0] RND_EXP = 32'h40100002;
`else
  localparam logic [31:0] RND_EXP = 32'h40100001;
`endif

  float_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .sclr(sclr), .operation_nd(operation_nd),
    .a(a), .b(b), .tag_in(tag_in),
    .rdy(rdy), .result(result), .tag_out(tag_out),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  // One operation sampled on the next edge; inputs then scrambled to prove they were registered.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
    operation_nd = 1'b1; a = x; b = y; tag_in = t;
    step();
    operation_nd = 1'b0; a = 32'hFFFF_FFFF; b = 32'h0000_0000; tag_in = 4'hF;
  endtask

  // Called right after issue(): rdy must stay low for 3 cycles, pulse once, then drop.
  task automatic expect_result(input string name, input logic [31:0] res,
                               input logic [3:0] t, input logic [2:0] flags);
    for (int i = 0; i < 3; i++) begin
      step();
      chk({name, "_early_rdy"}, {31'b0, rdy}, 32'd0);
    end
    step();
    chk({name, "_rdy"}, {31'b0, rdy}, 32'd1);
    chk({name, "_result"}, result, res);
    chk({name, "_tag"}, {28'b0, tag_out}, {28'b0, t});
    chk({name, "_flags"}, {29'b0, overflow, underflow, invalid}, {29'b0, flags});
    step();
    chk({name, "_rdy_drop"}, {31'b0, rdy}, 32'd0);
    chk({name, "_flags_drop"}, {29'b0, overflow, underflow, invalid}, 32'd0);
    chk({name, "_hold"}, result, res);
  endtask

  initial begin
    // Reset state
    sclr = 1'b1;
    step(); step();
    chk("rst_rdy", {31'b0, rdy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", {28'b0, tag_out}, 32'd0);
    chk("rst_flags", {29'b0, overflow, underflow, invalid}, 32'd0);
    sclr = 1'b0;
    step();
    chk("idle_rdy", {31'b0, rdy}, 32'd0);

    // Basic 2.0 x 2.0
    issue(32'h40000000, 32'h40000000, 4'd3);
    expect_result("basic", 32'h40800000, 4'd3, 3'b000);

    // Back-to-back: 2x4, 1.5x-1.5, 1x1
    operation_nd = 1'b1;
    a = 32'h40000000; b = 32'h40800000; tag_in = 4'd1; step();
    a = 32'h3FC00000; b = 32'hBFC00000; tag_in = 4'd2; step();
    a = 32'h3F800000; b = 32'h3F800000; tag_in = 4'd3; step();
    operation_nd = 1'b0;
    step();
    chk("b2b_pre_rdy", {31'b0, rdy}, 32'd0);
    step();
    chk("b2b0_rdy", {31'b0, rdy}, 32'd1);
    chk("b2b0_result", result, 32'h41000000);
    chk("b2b0_tag", {28'b0, tag_out}, 32'd1);
    step();
    chk("b2b1_rdy", {31'b0, rdy}, 32'd1);
    chk("b2b1_result", result, 32'hC0100000);
    chk("b2b1_tag", {28'b0, tag_out}, 32'd2);
    step();
    chk("b2b2_rdy", {31'b0, rdy}, 32'd1);
    chk("b2b2_result", result, 32'h3F800000);
    chk("b2b2_tag", {28'b0, tag_out}, 32'd3);
    step();
    chk("b2b_post_rdy", {31'b0, rdy}, 32'd0);
    chk("b2b_post_hold", result, 32'h3F800000);

    // Rounding of (1.5 + ulp)^2
    issue(32'h3FC00001, 32'h3FC00001, 4'd10);
    expect_result("round", RND_EXP, 4'd10, 3'b000);

    // Exceptions
    issue(32'h7F000000, 32'h40000000, 4'd11);
    expect_result("ovf", 32'h7F800000, 4'd11, 3'b100);
    issue(32'h00800000, 32'h00800000, 4'd12);
    expect_result("unf", 32'h00000000, 4'd12, 3'b010);
    issue(32'h00000000, 32'h7F800000, 4'd13);
    expect_result("inv", 32'h7FC00000, 4'd13, 3'b001);
    issue(32'h80000000, 32'h40000000, 4'd14);
    expect_result("negzero", 32'h80000000, 4'd14, 3'b000);
    issue(32'h7FC00000, 32'h3F800000, 4'd2);
    expect_result("nan_in", 32'h7FC00000, 4'd2, 3'b000);
    issue(32'h7F800000, 32'hC0000000, 4'd4);
    expect_result("inf_neg", 32'hFF800000, 4'd4, 3'b000);
    issue(32'h00000001, 32'h40000000, 4'd6);
    expect_result("denorm_flush", 32'h00000000, 4'd6, 3'b000);

    // Bubbles: pattern 1,0,1
    issue(32'h40000000, 32'h40000000, 4'd5);
    step();
    issue(32'h3F800000, 32'hC0000000, 4'd6);
    step();
    chk("bub_pre_rdy", {31'b0, rdy}, 32'd0);
    step();
    chk("bub0_rdy", {31'b0, rdy}, 32'd1);
    chk("bub0_result", result, 32'h40800000);
    chk("bub0_tag", {28'b0, tag_out}, 32'd5);
    step();
    chk("bub1_rdy", {31'b0, rdy}, 32'd0);
    chk("bub1_hold", result, 32'h40800000);
    chk("bub1_flags", {29'b0, overflow, underflow, invalid}, 32'd0);
    step();
    chk("bub2_rdy", {31'b0, rdy}, 32'd1);
    chk("bub2_result", result, 32'hC0000000);
    chk("bub2_tag", {28'b0, tag_out}, 32'd6);
    step();
    chk("bub_post_rdy", {31'b0, rdy}, 32'd0);

    // Reset mid-flight: two ops in flight, sclr two cycles later for one cycle
    issue(32'h40000000, 32'h40000000, 4'd7);
    issue(32'h3FC00000, 32'h3FC00000, 4'd8);
    step();
    sclr = 1'b1;
    #1;
    chk("midrst_rdy", {31'b0, rdy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_tag", {28'b0, tag_out}, 32'd0);
    step();
    sclr = 1'b0;
    issue(32'h40400000, 32'h40000000, 4'd9);
    chk("postrst_slot0_rdy", {31'b0, rdy}, 32'd0);
    expect_result("postrst", 32'h40C00000, 4'd9, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
